// File: rtl/imm_gen_stage_pkg.sv
// Shared opcode constants, immediate format enum and the buffered entry type
// for the fetch-to-decode immediate generation stage.
package imm_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  // Entries always carry the widest immediate; the top trims it to XLEN.
  localparam int XLEN_MAX = 64;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6,
    FMT_ZIMM  = 3'd7
  } imm_fmt_e;

  typedef struct packed {
    logic [31:0]         instr;
    logic [XLEN_MAX-1:0] imm;
    imm_fmt_e            fmt;
    logic                illegal;
  } imm_entry_t;

endpackage

// File: rtl/imm_gen_stage_if.sv
// Instruction-in / immediate-out handshake bundle; master drives instructions
// and consumes results, slave is the immediate generation stage.
interface imm_gen_if #(parameter int XLEN = 64);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_illegal;
  logic [31:0]     out_instr;

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_instr
  );

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_instr
  );
endinterface

// File: rtl/imm_gen_stage_extract.sv
// Combinational RV32I/RV64I immediate decoder: classifies the instruction
// format, flags unknown opcodes and builds the extended immediate.
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter bit EN_ZICSR = 1'b1
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt,
  output logic            illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_shift;
  logic       wide_shamt;

  assign opcode     = instr[6:0];
  assign funct3     = instr[14:12];
  assign is_shift   = (funct3 == 3'b001) || (funct3 == 3'b101);
  // Only the full-width OP-IMM shifts on RV64 use the sixth shamt bit.
  assign wide_shamt = (opcode == OP_IMM) && (XLEN == 64);

  always_comb begin
    fmt     = FMT_NONE;
    illegal = 1'b0;
    case (opcode)
      OP_LOAD, OP_JALR: fmt = FMT_I;
      OP_IMM:           fmt = is_shift ? FMT_SHAMT : FMT_I;
      OP_IMM32: begin
        if (XLEN == 32) illegal = 1'b1;
        else            fmt = is_shift ? FMT_SHAMT : FMT_I;
      end
      OP_STORE:         fmt = FMT_S;
      OP_BRANCH:        fmt = FMT_B;
      OP_LUI, OP_AUIPC: fmt = FMT_U;
      OP_JAL:           fmt = FMT_J;
      OP_SYSTEM: begin
        if (EN_ZICSR && funct3[2]) fmt = FMT_ZIMM;
      end
      OP_OP, OP_FENCE:  fmt = FMT_NONE;
      OP_OP32:          illegal = (XLEN == 32);
      default:          illegal = 1'b1;
    endcase
  end

  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I:     imm = XLEN'($signed(instr[31:20]));
      FMT_S:     imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      FMT_B:     imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      FMT_U:     imm = XLEN'($signed({instr[31:12], 12'b0}));
      FMT_J:     imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      FMT_SHAMT: imm = wide_shamt ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
      FMT_ZIMM:  imm = XLEN'(instr[19:15]);
      default:   imm = '0;
    endcase
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate generation stage: decodes each accepted instruction and
// buffers results through a main + skid entry pair under valid/ready flow control.
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter bit EN_ZICSR = 1'b1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     flush,
  imm_gen_if.slave bus
);

  logic [XLEN-1:0] dec_imm;
  imm_fmt_e        dec_fmt;
  logic            dec_illegal;
  imm_entry_t      dec_entry;

  imm_entry_t main_q, main_d;
  imm_entry_t skid_q, skid_d;
  logic       main_valid_q, main_valid_d;
  logic       skid_valid_q, skid_valid_d;
  logic       in_fire;
  logic       out_fire;

  imm_extract #(
    .XLEN     (XLEN),
    .EN_ZICSR (EN_ZICSR)
  ) u_extract (
    .instr   (bus.in_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  always_comb begin
    dec_entry.instr   = bus.in_instr;
    dec_entry.imm     = XLEN_MAX'(dec_imm);
    dec_entry.fmt     = dec_fmt;
    dec_entry.illegal = dec_illegal;
  end

  // Ready depends only on the skid register, keeping out_ready off the input path.
  assign bus.in_ready = ~skid_valid_q;
  assign in_fire      = bus.in_valid & ~skid_valid_q;
  assign out_fire     = main_valid_q & bus.out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (in_fire) begin
      if (!main_valid_q || out_fire) begin
        main_d       = dec_entry;
        main_valid_d = 1'b1;
      end else begin
        skid_d       = dec_entry;
        skid_valid_d = 1'b1;
      end
    end else if (out_fire) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign bus.out_valid   = main_valid_q;
  assign bus.out_imm     = main_q.imm[XLEN-1:0];
  assign bus.out_fmt     = main_q.fmt;
  assign bus.out_illegal = main_q.illegal;
  assign bus.out_instr   = main_q.instr;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Scoreboard bench: drives RV64 and RV32 instances in lockstep and checks both
// against a plain-arithmetic immediate model.
module tb_imm_gen_stage;

  typedef struct {
    logic [31:0]     instr;
    longint unsigned imm64;
    int              fmt64;
    bit              ill64;
    longint unsigned imm32;
    int              fmt32;
    bit              ill32;
  } exp_t;

  logic clk;
  logic rst_n;
  logic flush;
  int   checks;
  int   errors;
  exp_t sb[$];
  logic [6:0] op_table[13];

  imm_gen_if #(.XLEN(64)) bus64 ();
  imm_gen_if #(.XLEN(32)) bus32 ();

  assign bus32.in_valid  = bus64.in_valid;
  assign bus32.in_instr  = bus64.in_instr;
  assign bus32.out_ready = bus64.out_ready;

  imm_gen_stage #(.XLEN(64), .EN_ZICSR(1'b1)) dut64 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus64.slave)
  );

  imm_gen_stage #(.XLEN(32), .EN_ZICSR(1'b1)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus32.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: immediates built from the instruction fields with arithmetic.
  function automatic void refDecode(input logic [31:0] ins, input int xlen,
                                    output longint unsigned imm, output int fmt, output bit ill);
    int signed  s  = ins;
    int         op = int'(ins[6:0]);
    int         f3 = int'(ins[14:12]);
    bit         sh = (f3 == 1) || (f3 == 5);
    longint     v  = 0;
    fmt = 0;
    ill = 1'b0;
    case (op)
      'h03, 'h67: fmt = 1;
      'h13:       fmt = sh ? 6 : 1;
      'h1B:       if (xlen == 32) ill = 1'b1; else fmt = sh ? 6 : 1;
      'h23:       fmt = 2;
      'h63:       fmt = 3;
      'h37, 'h17: fmt = 4;
      'h6F:       fmt = 5;
      'h73:       fmt = (f3 >= 4) ? 7 : 0;
      'h33, 'h0F: fmt = 0;
      'h3B:       ill = (xlen == 32);
      default:    ill = 1'b1;
    endcase
    case (fmt)
      1: v = longint'(s >>> 20);
      2: v = longint'(s >>> 25) * 32 + longint'(ins[11:7]);
      3: v = longint'(s >>> 31) * 4096 + longint'(ins[7]) * 2048
             + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
      4: v = longint'(s >>> 12) * 4096;
      5: v = longint'(s >>> 31) * 1048576 + longint'(ins[19:12]) * 4096
             + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
      6: v = (op == 'h13 && xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
      7: v = longint'(ins[19:15]);
      default: v = 0;
    endcase
    imm = (xlen == 32) ? (longint'(v) & 64'h0000_0000_FFFF_FFFF) : longint'(v);
  endfunction

  function automatic exp_t makeExp(input logic [31:0] ins);
    exp_t e;
    e.instr = ins;
    refDecode(ins, 64, e.imm64, e.fmt64, e.ill64);
    refDecode(ins, 32, e.imm32, e.fmt32, e.ill32);
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: every presented result must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("valid_lockstep", 64'(bus32.out_valid), 64'(bus64.out_valid));
      checkOutput("ready_lockstep", 64'(bus32.in_ready), 64'(bus64.in_ready));
      if (bus64.out_valid) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_output", 64'(bus64.out_instr), 64'hX);
        end else begin
          checkOutput("instr64", 64'(bus64.out_instr), 64'(sb[0].instr));
          checkOutput("imm64", bus64.out_imm, sb[0].imm64);
          checkOutput("fmt64", 64'(bus64.out_fmt), 64'(sb[0].fmt64));
          checkOutput("ill64", 64'(bus64.out_illegal), 64'(sb[0].ill64));
          checkOutput("instr32", 64'(bus32.out_instr), 64'(sb[0].instr));
          checkOutput("imm32", 64'(bus32.out_imm), sb[0].imm32);
          checkOutput("fmt32", 64'(bus32.out_fmt), 64'(sb[0].fmt32));
          checkOutput("ill32", 64'(bus32.out_illegal), 64'(sb[0].ill32));
          if (bus64.out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  // Recorder: accepted instructions enter the scoreboard; a flush empties it.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (flush) sb.delete();
      else if (bus64.in_valid && bus64.in_ready) sb.push_back(makeExp(bus64.in_instr));
    end
  end

  task automatic applyStimulus(input logic [31:0] ins);
    int waited;
    @(posedge clk);
    #1;
    bus64.in_valid = 1'b1;
    bus64.in_instr = ins;
    waited = 0;
    @(negedge clk);
    while (!bus64.in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!bus64.in_ready) checkOutput("accept_timeout", 64'(bus64.in_ready), 64'd1);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    bus64.in_valid = 1'b0;
  endtask

  task automatic setReady(input logic r);
    @(posedge clk);
    #1;
    bus64.out_ready = r;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checkOutput("drain_empty", 64'(sb.size()), 64'd0);
    checkOutput("drain_valid", 64'(bus64.out_valid), 64'd0);
  endtask

  task automatic directed(input logic [31:0] ins, input logic [63:0] imm64,
                          input logic [2:0] fmt, input logic ill, input logic [31:0] imm32);
    applyStimulus(ins);
    idle();
    @(negedge clk);
    checkOutput("lat_valid", 64'(bus64.out_valid), 64'd1);
    checkOutput("dir_imm64", bus64.out_imm, imm64);
    checkOutput("dir_fmt", 64'(bus64.out_fmt), 64'(fmt));
    checkOutput("dir_ill", 64'(bus64.out_illegal), 64'(ill));
    checkOutput("dir_imm32", 64'(bus32.out_imm), 64'(imm32));
  endtask

  function automatic logic [31:0] randInstr();
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 15);
    if (k < 13) r[6:0] = op_table[k];
    return r;
  endfunction

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_valid"}, 64'(bus64.out_valid), 64'd0);
    checkOutput({tag, "_imm"}, bus64.out_imm, 64'd0);
    checkOutput({tag, "_fmt"}, 64'(bus64.out_fmt), 64'd0);
    checkOutput({tag, "_ill"}, 64'(bus64.out_illegal), 64'd0);
    checkOutput({tag, "_instr"}, 64'(bus64.out_instr), 64'd0);
    checkOutput({tag, "_ready"}, 64'(bus64.in_ready), 64'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    op_table = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h23, 7'h63, 7'h37,
                 7'h17, 7'h6F, 7'h73, 7'h33, 7'h3B, 7'h0F};
    rst_n           = 1'b0;
    flush           = 1'b0;
    bus64.in_valid  = 1'b0;
    bus64.in_instr  = '0;
    bus64.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checkResetOutputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkResetOutputs("post_reset");

    $display("[TB] directed decode");
    directed(32'hFFC12083, 64'hFFFF_FFFF_FFFF_FFFC, 3'd1, 1'b0, 32'hFFFF_FFFC);
    directed(32'hFE000CE3, 64'hFFFF_FFFF_FFFF_FFF8, 3'd3, 1'b0, 32'hFFFF_FFF8);
    directed(32'h800002B7, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0, 32'h8000_0000);
    directed(32'h43F0D093, 64'h0000_0000_0000_003F, 3'd6, 1'b0, 32'h0000_001F);
    directed(32'h00000000, 64'h0, 3'd0, 1'b1, 32'h0);
    drain();

    $display("[TB] back-pressure stream");
    setReady(1'b0);
    applyStimulus(32'h00A00093);
    applyStimulus(32'h00112223);
    idle();
    @(negedge clk);
    checkOutput("bp_in_ready_low", 64'(bus64.in_ready), 64'd0);
    @(negedge clk);
    checkOutput("bp_stall_size", 64'(sb.size()), 64'd2);
    fork
      begin
        applyStimulus(32'h0000006F);
        applyStimulus(32'h12345037);
        idle();
      end
      setReady(1'b1);
    join
    drain();

    $display("[TB] flush cases");
    setReady(1'b0);
    applyStimulus(32'h00500113);
    @(posedge clk);
    #1;
    flush          = 1'b1;
    bus64.in_valid = 1'b1;
    bus64.in_instr = 32'h00600193;
    @(posedge clk);
    #1;
    flush          = 1'b0;
    bus64.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("flush1_valid", 64'(bus64.out_valid), 64'd0);
    applyStimulus(32'h00700213);
    applyStimulus(32'h00800293);
    @(posedge clk);
    #1;
    flush          = 1'b1;
    bus64.in_valid = 1'b1;
    bus64.in_instr = 32'h00900313;
    @(posedge clk);
    #1;
    flush          = 1'b0;
    bus64.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("flush2_valid", 64'(bus64.out_valid), 64'd0);
    checkOutput("flush2_ready", 64'(bus64.in_ready), 64'd1);
    setReady(1'b1);
    drain();

    $display("[TB] reset mid-stream");
    setReady(1'b0);
    applyStimulus(32'hABCDE0B7);
    applyStimulus(32'h7FF00093);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    sb.delete();
    #1;
    checkResetOutputs("async_reset");
    bus64.in_valid  = 1'b0;
    bus64.out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkResetOutputs("after_async");

    $display("[TB] random traffic");
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #1;
      bus64.in_valid  = ($urandom_range(0, 3) != 0);
      bus64.in_instr  = randInstr();
      bus64.out_ready = ($urandom_range(0, 3) != 0);
      flush           = ($urandom_range(0, 39) == 0);
    end
    @(posedge clk);
    #1;
    bus64.in_valid  = 1'b0;
    bus64.out_ready = 1'b1;
    flush           = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_gen_stage.md
# imm_gen_stage

Registered, parametrised immediate-generation stage between fetch and decode in the RISC-V core. It accepts one 32-bit instruction per cycle over a valid/ready handshake and extracts the sign- or zero-extended immediate for every RV32I/RV64I format (I, S, B, U, J, shift-amount, CSR zimm). It classifies the format, flags unknown opcodes, and buffers through a 2-entry skid register so back-pressure never drops or reorders instructions.

## Interface
- `XLEN`, 64, datapath width; legal values are 32 and 64.
- `EN_ZICSR`, 1, when 1, SYSTEM with funct3[2]=1 yields the zimm format.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous kill of all buffered entries.
- `in_valid`  in  1  instruction valid.
- `in_ready`  out  1  stage can accept.
- `in_instr`  in  32  instruction word.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts.
- `out_imm`  out  XLEN  extracted immediate.
- `out_fmt`  out  3  format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 ZIMM.
- `out_illegal`  out  1  opcode not recognised.
- `out_instr`  out  32  instruction pass-through.

## Operation
- Opcode map:
  - 0000011, 1100111 → I.
  - 0010011 → I, or SHAMT when funct3 is 001/101.
  - 0011011 → SHAMT (funct3 001/101) or I; illegal when XLEN=32.
  - 0100011 → S. 1100011 → B. 0110111, 0010111 → U. 1101111 → J.
  - 1110011 → ZIMM when funct3[2]=1 and EN_ZICSR=1, else NONE.
  - 0110011, 0001111 → NONE; 0111011 → NONE (illegal when XLEN=32).
  - Anything else → NONE with out_illegal=1.
- Immediate values:
  - I: sign-extend [31:20].
  - S: sign-extend {[31:25],[11:7]}.
  - B: sign-extend {[31],[7],[30:25],[11:8],1'b0}, a byte offset with bit 0 = 0.
  - J: sign-extend {[31],[19:12],[20],[30:21],1'b0}, a byte offset with bit 0 = 0.
  - U: sign-extend {[31:12],12'b0} to XLEN.
  - SHAMT: zero-extend [25:20] for opcode 0010011 at XLEN=64, else zero-extend [24:20].
  - ZIMM: zero-extend [19:15].
  - NONE: 0.
- Buffering uses a main entry (drives the outputs) and a skid entry.
  - Transfer = valid && ready on each side.
  - in_ready = ~skid_valid, taken from a register, with no combinational path from out_ready.
  - Accept while main is empty or draining: the decoded result loads main.
  - Accept while main is held (out_valid && ~out_ready): the result loads skid.
  - Main drains while skid is full: skid moves to main, and skid clears.
- Flush: main_valid and skid_valid clear on the next edge. A same-cycle input accept is discarded, and a same-cycle output transfer still completes.

## Timing
- Latency is 1 cycle: an accept at edge N puts the result on the outputs after edge N. Throughput is 1/cycle while out_ready=1.
- Reset values:
  - out_valid=0, out_imm=0, out_fmt=0, out_illegal=0, out_instr=0.
  - skid cleared, so in_ready=1 once rst_n is deasserted.
- Reset mid-operation drops every buffered entry immediately (asynchronous).
- Outputs are held stable while out_valid && ~out_ready.
- in_ready falls on the edge after the skid loads and rises on the edge after the skid drains.
- Both entries full with out_ready=0: in_ready=0 and no state changes.

## Structure
- Package `imm_pkg` holds:
  - opcode localparams: OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_SYSTEM, OP_OP, OP_OP32, OP_FENCE;
  - the 3-bit `imm_fmt_e` enum;
  - the entry struct {instr, imm, fmt, illegal}.
- Sub-module `imm_extract`: purely combinational decode of instr → {imm, fmt, illegal}, parametrised by XLEN and EN_ZICSR.
- The top level contains only the skid/main registers and the handshake logic.

## Test plan
- lw 0xFFC12083, XLEN=64 → out_imm=0xFFFFFFFFFFFFFFFC, fmt=I, out_valid one cycle after accept.
- beq 0xFE000CE3 → out_imm=0xFFFFFFFFFFFFFFF8, fmt=B.
- lui 0x800002B7 → 0xFFFFFFFF80000000 at XLEN=64, 0x80000000 at XLEN=32.
- srai 0x43F0D093 → out_imm=0x3F, fmt=SHAMT (funct7 bit 30 excluded). 0x00000000 → illegal=1, imm=0, fmt=NONE.
- Stream 4 instructions with out_ready=0 for 3 cycles:
  - in_ready drops after the second accept;
  - all 4 emerge in order with no duplicates once out_ready=1.
- Edge cases:
  - flush while both entries full, together with an in_valid accept → out_valid=0 next cycle, nothing emitted, in_ready=1.
  - rst_n pulsed low mid-stream → all outputs reset asynchronously.
